// File: rtl/ov9655_pkg.sv
// Shared definitions for the OV9655 parallel-bus emulator and its capture side.
// Holds the frame state encoding, RGB565 field positions and byte packing.
package ov9655_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  localparam int unsigned R_LSB = 16;
  localparam int unsigned R_W   = 5;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned G_W   = 6;
  localparam int unsigned B_LSB = 0;
  localparam int unsigned B_W   = 5;

  // First byte carries {R, G[5:3]}, second byte carries {G[2:0], B}.
  function automatic logic [7:0] pack_byte(input logic [31:0] word, input logic second);
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
    r = word[R_LSB +: R_W];
    g = word[G_LSB +: G_W];
    b = word[B_LSB +: B_W];
    return second ? {g[2:0], b} : {r, g[5:3]};
  endfunction

endpackage

// File: rtl/ov9655_pclk_gen.sv
// Free-running pixel clock divider with single-cycle edge strobes.
// The strobes mark the system-clock cycle in which pclk_o is about to toggle.
module ov9655_pclk_gen #(
  parameter logic [7:0] C_PCLK_DIV = 8'd3
) (
  input  logic clk,
  input  logic resetn,
  output logic pclk_o,
  output logic fall_evt,
  output logic rise_evt
);

  logic [7:0] cnt;
  logic       tc;

  assign tc       = (cnt == C_PCLK_DIV - 8'd1);
  assign fall_evt = tc && pclk_o;
  assign rise_evt = tc && !pclk_o;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      pclk_o <= 1'b0;
    end else if (tc) begin
      cnt    <= '0;
      pclk_o <= ~pclk_o;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ov9655_tx.sv
// OV9655 sensor-side bus emulator: turns a 32-bit RGB565 pixel stream into
// pclk/href/vsync/data with line and frame blanking.
module ov9655_tx
  import ov9655_pkg::*;
#(
  parameter logic [7:0]  C_PCLK_DIV     = 8'd3,
  parameter logic [15:0] C_HBLANK       = 16'd64,
  parameter logic [7:0]  C_VSYNC_LINES  = 8'd3,
  parameter logic [7:0]  C_VBACK_LINES  = 8'd17,
  parameter logic [7:0]  C_VFRONT_LINES = 8'd10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en_i,
  input  logic [15:0] line_pixels_i,
  input  logic [15:0] frame_lines_i,
  input  logic [31:0] s_dat_i,
  input  logic        s_valid_i,
  input  logic        s_last_i,
  input  logic        s_sof_i,
  output logic        s_ready_o,
  output logic        pclk_o,
  output logic [9:0]  dat_o,
  output logic        href_o,
  output logic        vsync_o,
  output logic        busy_o,
  output logic [31:0] frames_o,
  output logic        underrun_o,
  output logic        sync_err_o
);

  logic        fall_evt;
  state_t      state, state_n;
  logic [17:0] h_cnt, h_n;
  logic [15:0] v_cnt, v_n;
  logic [15:0] lp, fl;
  logic [17:0] act_len, line_len;
  logic [15:0] state_lines;
  logic        line_end, last_line;
  logic        enter_vs, frame_done;
  logic        pix_n, consume, exp_last, exp_sof;
  logic [31:0] hold_w;
  logic        hold_last, hold_sof, full, pair_ok;

  ov9655_pclk_gen #(
    .C_PCLK_DIV (C_PCLK_DIV)
  ) u_pclk (
    .clk      (clk),
    .resetn   (resetn),
    .pclk_o   (pclk_o),
    .fall_evt (fall_evt),
    .rise_evt ()
  );

  assign act_len   = {1'b0, lp, 1'b0};
  assign line_len  = act_len + {2'b00, C_HBLANK};
  assign line_end  = (h_cnt == line_len - 18'd1);
  assign last_line = (v_cnt == state_lines - 16'd1);

  always_comb begin
    unique case (state)
      ST_VSYNC:  state_lines = {8'h00, C_VSYNC_LINES};
      ST_VBACK:  state_lines = {8'h00, C_VBACK_LINES};
      ST_ACTIVE: state_lines = fl;
      default:   state_lines = {8'h00, C_VFRONT_LINES};
    endcase
  end

  // Registers hold the bus position currently on the pins; on each pclk fall
  // the next position is computed and the outputs are driven from it.
  always_comb begin
    state_n    = state;
    h_n        = h_cnt;
    v_n        = v_cnt;
    enter_vs   = 1'b0;
    frame_done = 1'b0;
    if (state == ST_IDLE) begin
      if (en_i) begin
        state_n  = ST_VSYNC;
        h_n      = '0;
        v_n      = '0;
        enter_vs = 1'b1;
      end
    end else if (!line_end) begin
      h_n = h_cnt + 18'd1;
    end else begin
      h_n = '0;
      if (!last_line) begin
        v_n = v_cnt + 16'd1;
      end else begin
        v_n = '0;
        unique case (state)
          ST_VSYNC:  state_n = ST_VBACK;
          ST_VBACK:  state_n = ST_ACTIVE;
          ST_ACTIVE: state_n = ST_VFRONT;
          default: begin
            frame_done = 1'b1;
            enter_vs   = en_i;
            state_n    = en_i ? ST_VSYNC : ST_IDLE;
          end
        endcase
      end
    end
  end

  assign pix_n    = (state_n == ST_ACTIVE) && (h_n < act_len);
  // A pair that started empty is not consumed, so a late word is kept whole.
  assign consume  = fall_evt && pix_n && h_n[0] && pair_ok;
  assign exp_last = (h_n == act_len - 18'd1);
  assign exp_sof  = (v_n == 16'd0) && (h_n == 18'd1);

  assign busy_o    = (state != ST_IDLE);
  assign s_ready_o = busy_o && (!full || consume);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      h_cnt    <= '0;
      v_cnt    <= '0;
      lp       <= '0;
      fl       <= '0;
      href_o   <= 1'b0;
      vsync_o  <= 1'b0;
      dat_o    <= '0;
      pair_ok  <= 1'b0;
      frames_o <= '0;
    end else if (fall_evt) begin
      state   <= state_n;
      h_cnt   <= h_n;
      v_cnt   <= v_n;
      vsync_o <= (state_n == ST_VSYNC);
      href_o  <= pix_n;
      if (enter_vs) begin
        lp <= line_pixels_i;
        fl <= frame_lines_i;
      end
      if (!pix_n) begin
        dat_o <= '0;
      end else if (!h_n[0]) begin
        pair_ok <= full;
        dat_o   <= full ? {pack_byte(hold_w, 1'b0), 2'b00} : '0;
      end else begin
        dat_o <= pair_ok ? {pack_byte(hold_w, 1'b1), 2'b00} : '0;
      end
      if (frame_done) begin
        frames_o <= frames_o + 32'd1;
      end else if (enter_vs) begin
        frames_o <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_w     <= '0;
      hold_last  <= 1'b0;
      hold_sof   <= 1'b0;
      full       <= 1'b0;
      underrun_o <= 1'b0;
      sync_err_o <= 1'b0;
    end else begin
      if (s_valid_i && s_ready_o) begin
        hold_w    <= s_dat_i;
        hold_last <= s_last_i;
        hold_sof  <= s_sof_i;
        full      <= 1'b1;
      end else if (consume) begin
        full <= 1'b0;
      end
      if (state == ST_IDLE && !en_i) begin
        underrun_o <= 1'b0;
        sync_err_o <= 1'b0;
      end else begin
        if (fall_evt && pix_n && !h_n[0] && !full)
          underrun_o <= 1'b1;
        if (consume && ((hold_last != exp_last) || (hold_sof != exp_sof)))
          sync_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov9655_tx.sv
// Directed bench for ov9655_tx: 4x2 frames with an 8-cycle horizontal blank,
// pclk divided by 3, checking timing, byte mapping, flow control and flags.
module tb_ov9655_tx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en_i;
  logic [15:0] line_pixels_i;
  logic [15:0] frame_lines_i;
  logic [31:0] s_dat_i;
  logic        s_valid_i;
  logic        s_last_i;
  logic        s_sof_i;
  logic        s_ready_o;
  logic        pclk_o;
  logic [9:0]  dat_o;
  logic        href_o;
  logic        vsync_o;
  logic        busy_o;
  logic [31:0] frames_o;
  logic        underrun_o;
  logic        sync_err_o;

  always #5 clk = ~clk;

  ov9655_tx #(
    .C_PCLK_DIV     (8'd3),
    .C_HBLANK       (16'd8),
    .C_VSYNC_LINES  (8'd3),
    .C_VBACK_LINES  (8'd17),
    .C_VFRONT_LINES (8'd10)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .en_i          (en_i),
    .line_pixels_i (line_pixels_i),
    .frame_lines_i (frame_lines_i),
    .s_dat_i       (s_dat_i),
    .s_valid_i     (s_valid_i),
    .s_last_i      (s_last_i),
    .s_sof_i       (s_sof_i),
    .s_ready_o     (s_ready_o),
    .pclk_o        (pclk_o),
    .dat_o         (dat_o),
    .href_o        (href_o),
    .vsync_o       (vsync_o),
    .busy_o        (busy_o),
    .frames_o      (frames_o),
    .underrun_o    (underrun_o),
    .sync_err_o    (sync_err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int   cyc = 0, last_rise = 0, rise_period = 0;
  int   n_vs, n_href, n_burst, n_cap, bad_dat, n_acc;
  logic prev_pclk = 1'b0, prev_href = 1'b0, saw_fall = 1'b0;
  logic [7:0] cap [64];

  logic [31:0] src_w    [32];
  logic        src_last [32];
  logic        src_sof  [32];
  int          src_idx, src_lim;

  logic [7:0] exp_b [16] = '{8'hFF, 8'hFF, 8'h81, 8'h10, 8'h08, 8'h01, 8'h00, 8'h20,
                             8'h04, 8'h00, 8'h6A, 8'h54, 8'hA9, 8'h55, 8'h56, 8'hA0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    if (src_idx < src_lim) begin
      s_valid_i = 1'b1;
      s_dat_i   = src_w[src_idx];
      s_last_i  = src_last[src_idx];
      s_sof_i   = src_sof[src_idx];
    end else begin
      s_valid_i = 1'b0;
      s_dat_i   = '0;
      s_last_i  = 1'b0;
      s_sof_i   = 1'b0;
    end
  endtask

  task automatic set_table();
    src_w[0] = 32'h001F3F1F; src_w[1] = 32'h00100810;
    src_w[2] = 32'h00010001; src_w[3] = 32'h00000100;
    src_w[4] = 32'h00002000; src_w[5] = 32'hABCD1234;
    src_w[6] = 32'h00150A15; src_w[7] = 32'h000A3500;
    for (int i = 0; i < 8; i++) begin
      src_sof[i]  = (i == 0);
      src_last[i] = ((i % 4) == 3);
    end
  endtask

  task automatic clr_mon();
    n_vs = 0; n_href = 0; n_burst = 0; n_cap = 0; bad_dat = 0; n_acc = 0;
    prev_href = 1'b0;
  endtask

  // One system clock: note acceptance before the edge, sample after it.
  task automatic step();
    logic acc;
    @(negedge clk);
    acc = s_valid_i && s_ready_o;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      n_acc++;
      src_idx++;
      drive_src();
    end
    saw_fall = prev_pclk && !pclk_o;
    if (saw_fall) begin
      if (vsync_o) n_vs++;
      if (href_o) begin
        n_href++;
        if (!prev_href) n_burst++;
        if (n_cap < 64) cap[n_cap] = dat_o[9:2];
        n_cap++;
      end else if (dat_o != 10'd0) begin
        bad_dat++;
      end
      if (dat_o[1:0] != 2'b00) bad_dat++;
      prev_href = href_o;
    end
    if (!prev_pclk && pclk_o) begin
      rise_period = cyc - last_rise;
      last_rise   = cyc;
    end
    prev_pclk = pclk_o;
  endtask

  function automatic logic [31:0] sig(input int sel);
    case (sel)
      0:       return {31'b0, busy_o};
      1:       return frames_o;
      2:       return {31'b0, href_o};
      default: return {31'b0, saw_fall};
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic [31:0] val, input int budget, input string tag);
    for (int i = 0; i < budget && sig(sel) !== val; i++) step();
    chk(tag, sig(sel), val);
  endtask

  initial begin
    resetn = 1'b0; en_i = 1'b0;
    line_pixels_i = 16'd4; frame_lines_i = 16'd2;
    set_table();
    src_idx = 0; src_lim = 8;
    drive_src();
    clr_mon();

    // Reset values
    #12;
    chk("rst_pclk", pclk_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_href", href_o, 0);
    chk("rst_vsync", vsync_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", s_ready_o, 0);
    chk("rst_frames", frames_o, 0);
    chk("rst_flags", {underrun_o, sync_err_o}, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Idle: pclk runs, no handshake while a word is offered
    repeat (40) step();
    chk("pclk_period", rise_period, 6);
    chk("idle_ready", s_ready_o, 0);
    chk("idle_acc", n_acc, 0);
    chk("idle_vsync", vsync_o, 0);

    // Single frame with en_i pulsed
    clr_mon();
    en_i = 1'b1;
    wait_for(0, 1, 20, "b_start");
    en_i = 1'b0;
    wait_for(0, 0, 5000, "b_end");
    chk("b_frames", frames_o, 1);
    chk("b_vsync_pclks", n_vs, 48);
    chk("b_href_pclks", n_href, 16);
    chk("b_bursts", n_burst, 2);
    chk("b_accepted", n_acc, 8);
    chk("b_ncap", n_cap, 16);
    chk("b_dat_idle", bad_dat, 0);
    chk("b_underrun", underrun_o, 0);
    chk("b_sync_err", sync_err_o, 0);
    for (int i = 0; i < 16; i++) chk($sformatf("b_byte%0d", i), cap[i], exp_b[i]);

    // Continuous valid across three frames
    for (int i = 0; i < 24; i++) begin
      src_w[i]    = i * 32'h00010101;
      src_sof[i]  = ((i % 8) == 0);
      src_last[i] = ((i % 4) == 3);
    end
    src_idx = 0; src_lim = 24;
    drive_src();
    clr_mon();
    en_i = 1'b1;
    wait_for(0, 1, 20, "c_start");
    wait_for(1, 1, 5000, "c_frame1");
    chk("c_acc1", n_acc, 9);
    wait_for(1, 2, 5000, "c_frame2");
    chk("c_acc2", n_acc, 17);
    chk("c_underrun", underrun_o, 0);
    chk("c_sync_err", sync_err_o, 0);
    en_i = 1'b0;
    wait_for(0, 0, 5000, "c_end");
    chk("c_frames", frames_o, 3);
    chk("c_acc3", n_acc, 24);

    // Underrun: only three words supplied
    set_table();
    src_idx = 0; src_lim = 3;
    drive_src();
    clr_mon();
    en_i = 1'b1;
    wait_for(0, 1, 20, "d_start");
    wait_for(1, 1, 5000, "d_frame1");
    chk("d_underrun", underrun_o, 1);
    chk("d_byte0", cap[0], 8'hFF);
    chk("d_byte5", cap[5], 8'h01);
    chk("d_byte6", cap[6], 8'h00);
    chk("d_byte7", cap[7], 8'h00);
    chk("d_accepted", n_acc, 3);
    chk("d_sync_err", sync_err_o, 0);
    en_i = 1'b0;
    wait_for(0, 0, 5000, "d_end");
    repeat (3) step();
    chk("d_underrun_clr", underrun_o, 0);

    // Misplaced last on the second pixel
    set_table();
    src_last[1] = 1'b1;
    src_idx = 0; src_lim = 8;
    drive_src();
    clr_mon();
    en_i = 1'b1;
    wait_for(0, 1, 20, "e_start");
    wait_for(1, 1, 5000, "e_frame1");
    chk("e_sync_err", sync_err_o, 1);
    chk("e_href_pclks", n_href, 16);
    chk("e_bursts", n_burst, 2);
    chk("e_accepted", n_acc, 8);
    chk("e_underrun", underrun_o, 0);
    en_i = 1'b0;
    wait_for(0, 0, 5000, "e_end");
    repeat (3) step();
    chk("e_sync_clr", sync_err_o, 0);

    // Asynchronous reset in the middle of an active line
    set_table();
    src_idx = 0; src_lim = 8;
    drive_src();
    clr_mon();
    en_i = 1'b1;
    wait_for(0, 1, 20, "f_start");
    wait_for(2, 1, 3000, "f_href");
    #2 resetn = 1'b0;
    #1;
    chk("f_pclk", pclk_o, 0);
    chk("f_dat", dat_o, 0);
    chk("f_href", href_o, 0);
    chk("f_vsync", vsync_o, 0);
    chk("f_busy", busy_o, 0);
    chk("f_ready", s_ready_o, 0);
    chk("f_frames", frames_o, 0);
    @(negedge clk);
    resetn    = 1'b1;
    prev_pclk = 1'b0;
    saw_fall  = 1'b0;
    wait_for(3, 1, 20, "f_first_fall");
    chk("f_vsync_rise", vsync_o, 1);
    chk("f_busy_run", busy_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
